// File: rtl/mem_1w1r_fifo.sv
// Valid/ready FIFO on a 1-write/1-read memory with registered read address.
// A 2-entry output buffer hides the read latency so one word per cycle flows.

module mem_1w1r #(
    parameter int AW    = 7,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             write,
    input  logic [AW-1:0]    writeaddress,
    input  logic [WIDTH-1:0] writedata,
    input  logic             read,
    input  logic [AW-1:0]    readaddress,
    output logic [WIDTH-1:0] readdata
);
    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    raddr_q;

    always_ff @(posedge clk) begin
        if (write) mem[writeaddress] <= writedata;
        if (read) raddr_q <= readaddress;
    end

    assign readdata = mem[raddr_q];
endmodule

module mem_1w1r_fifo #(
    parameter int ELEMENTS_W = 7,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ELEMENTS_W:0]   count
);
    localparam int CW    = ELEMENTS_W + 1;
    localparam int DEPTH = 2**ELEMENTS_W;

    logic [ELEMENTS_W-1:0] wptr, rptr;
    logic [CW-1:0]         mem_cnt;
    logic                  rd_pend;
    logic [1:0]            obuf_cnt;
    logic [1:0]            obuf_left;
    logic [WIDTH-1:0]      obuf0, obuf1;
    logic [WIDTH-1:0]      readdata;
    logic                  push, pop, issue;

    assign count     = mem_cnt + CW'(rd_pend) + CW'(obuf_cnt);
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (obuf_cnt != 2'd0);
    assign out_data  = obuf0;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Only issue a read if the buffer will have room when the data lands.
    assign issue = (mem_cnt != '0) &&
                   ((3'(obuf_cnt) + 3'(rd_pend)) < (3'd2 + 3'(pop)));

    assign obuf_left = obuf_cnt - 2'(pop);

    mem_1w1r #(
        .AW   (ELEMENTS_W),
        .WIDTH(WIDTH)
    ) u_mem (
        .clk         (clk),
        .write       (push),
        .writeaddress(wptr),
        .writedata   (in_data),
        .read        (issue),
        .readaddress (rptr),
        .readdata    (readdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            rd_pend  <= 1'b0;
            obuf_cnt <= 2'd0;
            obuf0    <= '0;
            obuf1    <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (issue) rptr <= rptr + 1'b1;
            mem_cnt  <= mem_cnt + CW'(push) - CW'(issue);
            rd_pend  <= issue;
            obuf_cnt <= obuf_left + 2'(rd_pend);
            if (pop) obuf0 <= obuf1;
            // readdata is only valid this cycle; capture behind whatever stays.
            if (rd_pend) begin
                if (obuf_left == 2'd0) obuf0 <= readdata;
                else                   obuf1 <= readdata;
            end
        end
    end
endmodule
